// File: rtl/writeback_buffered_if.sv
// Writeback bus interface.
// Groups the memory-stage -> writeback entry signals, the in-order load
// response strobe, flush, and the register-file write / status outputs.
//   slave  : the writeback block (consumes wb_i_*, drives wb_o_*)
//   master : whatever feeds it (drives wb_i_*, observes wb_o_*)
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef SYSTEM
`define SYSTEM 7'b1110011
`endif

interface wb_if #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int DEPTH       = 4
);
  logic                      wb_i_ce;
  logic [`OPCODE_WIDTH-1:0]  wb_i_opcode;
  logic [FUNCT_WIDTH-1:0]    wb_i_funct;
  logic [1:0]                wb_i_addr_lsb;
  logic                      wb_i_we_rd;
  logic [AWIDTH-1:0]         wb_i_rd_addr;
  logic [DWIDTH-1:0]         wb_i_rd_data;
  logic [DWIDTH-1:0]         wb_i_csr;
  logic                      wb_i_load_valid;
  logic [DWIDTH-1:0]         wb_i_data_load;
  logic                      wb_i_flush;
  logic                      wb_o_stall;
  logic [$clog2(DEPTH):0]    wb_o_count;
  logic                      wb_o_we_rd;
  logic [AWIDTH-1:0]         wb_o_rd_addr;
  logic [DWIDTH-1:0]         wb_o_rd_data;
  logic                      wb_o_load_err;

  modport slave (
    input  wb_i_ce, wb_i_opcode, wb_i_funct, wb_i_addr_lsb, wb_i_we_rd,
           wb_i_rd_addr, wb_i_rd_data, wb_i_csr, wb_i_load_valid,
           wb_i_data_load, wb_i_flush,
    output wb_o_stall, wb_o_count, wb_o_we_rd, wb_o_rd_addr, wb_o_rd_data,
           wb_o_load_err
  );

  modport master (
    output wb_i_ce, wb_i_opcode, wb_i_funct, wb_i_addr_lsb, wb_i_we_rd,
           wb_i_rd_addr, wb_i_rd_data, wb_i_csr, wb_i_load_valid,
           wb_i_data_load, wb_i_flush,
    input  wb_o_stall, wb_o_count, wb_o_we_rd, wb_o_rd_addr, wb_o_rd_data,
           wb_o_load_err
  );
endinterface

// File: rtl/writeback_buffered.sv
// Buffered writeback stage.
// Queues up to DEPTH retiring instructions in order, pairs loads with
// in-order load responses held in a separate data FIFO, extracts sub-word
// load data, selects CSR data for SYSTEM ops and issues at most one
// registered register-file write per cycle. Flush drops all queued work and
// arms a discard down-counter that swallows responses of flushed loads.
// Ports:
//   wb_clk      clock, rising edge
//   wb_rst      synchronous active-high reset
//   bus         wb_if.slave (entry, load response, flush, write/status outs)
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef SYSTEM
`define SYSTEM 7'b1110011
`endif

module writeback_buffered #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int DEPTH       = 4
) (
  input  logic wb_clk,
  input  logic wb_rst,
  wb_if.slave  bus
);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  // Room for several back-to-back flushes' worth of outstanding responses.
  localparam int DISC_W = CW + 3;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // instruction queue storage
  logic                   e_load_q  [DEPTH];
  logic                   e_sys_q   [DEPTH];
  logic [FUNCT_WIDTH-1:0] e_funct_q [DEPTH];
  logic [1:0]             e_lsb_q   [DEPTH];
  logic                   e_we_q    [DEPTH];
  logic [AWIDTH-1:0]      e_rd_q    [DEPTH];
  logic [DWIDTH-1:0]      e_data_q  [DEPTH];
  logic [DWIDTH-1:0]      e_csr_q   [DEPTH];
  // load-data FIFO storage
  logic [DWIDTH-1:0]      lf_mem_q  [DEPTH];

  logic [PW-1:0]     q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CW-1:0]     q_cnt_q, q_cnt_d;
  logic [PW-1:0]     lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
  logic [CW-1:0]     lf_cnt_q, lf_cnt_d;
  logic [CW-1:0]     loads_q, loads_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;

  logic              stall, flush, lv;
  logic              is_load_in, is_sys_in;
  logic              enq, retire, head_load, pop_lf;
  logic              resp_push, resp_drop, resp_bad, flush_consume;
  logic [CW-1:0]     unans;
  logic [DISC_W:0]   disc_sum;
  logic [DWIDTH-1:0] head_val;

  function automatic logic [DWIDTH-1:0] extract(
    input logic [DWIDTH-1:0]      word,
    input logic [FUNCT_WIDTH-1:0] funct,
    input logic [1:0]             lsb
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lsb, 3'b000} +: 8];
    h = word[{lsb[1], 4'b0000} +: 16];
    case (funct)
      3'b000:  extract = {{(DWIDTH-8){b[7]}}, b};
      3'b001:  extract = {{(DWIDTH-16){h[15]}}, h};
      3'b100:  extract = {{(DWIDTH-8){1'b0}}, b};
      3'b101:  extract = {{(DWIDTH-16){1'b0}}, h};
      default: extract = word;
    endcase
  endfunction

  always_comb begin
    stall      = (q_cnt_q == FULL);
    flush      = bus.wb_i_flush;
    lv         = bus.wb_i_load_valid;
    is_load_in = (bus.wb_i_opcode == `LOAD);
    is_sys_in  = (bus.wb_i_opcode == `SYSTEM);
    unans      = loads_q - lf_cnt_q;

    // Full is judged on the registered count: no same-cycle slot reuse.
    enq       = bus.wb_i_ce & ~stall & ~flush;
    head_load = e_load_q[q_rd_q];
    // A response arriving this cycle is not visible to the head until next.
    retire    = ~flush & (q_cnt_q != '0) & (~head_load | (lf_cnt_q != '0));
    pop_lf    = retire & head_load;

    resp_bad      = lv & (unans == '0) & (disc_q == '0);
    resp_push     = lv & ~flush & (unans != '0) & (disc_q == '0);
    resp_drop     = lv & ~flush & (disc_q != '0);
    flush_consume = lv & flush & ~resp_bad;

    head_val = e_sys_q[q_rd_q] ? e_csr_q[q_rd_q] : e_data_q[q_rd_q];
    if (head_load)
      head_val = extract(lf_mem_q[lf_rd_q], e_funct_q[q_rd_q], e_lsb_q[q_rd_q]);
  end

  always_comb begin
    q_wr_d   = q_wr_q;
    q_rd_d   = q_rd_q;
    q_cnt_d  = q_cnt_q;
    lf_wr_d  = lf_wr_q;
    lf_rd_d  = lf_rd_q;
    lf_cnt_d = lf_cnt_q;
    loads_d  = loads_q;
    disc_d   = disc_q;
    err_d    = err_q | resp_bad;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    disc_sum = '0;

    if (flush) begin
      q_wr_d   = '0;
      q_rd_d   = '0;
      q_cnt_d  = '0;
      lf_wr_d  = '0;
      lf_rd_d  = '0;
      lf_cnt_d = '0;
      loads_d  = '0;
      // Every unanswered load still owes a response; discard them all.
      disc_sum = {1'b0, disc_q} + (DISC_W+1)'(unans)
               - (DISC_W+1)'(flush_consume);
      disc_d   = disc_sum[DISC_W] ? '1 : disc_sum[DISC_W-1:0];
    end else begin
      if (enq) q_wr_d = q_wr_q + 1'b1;
      if (retire) q_rd_d = q_rd_q + 1'b1;
      q_cnt_d = q_cnt_q + CW'(enq) - CW'(retire);

      if (resp_push) lf_wr_d = lf_wr_q + 1'b1;
      if (pop_lf) lf_rd_d = lf_rd_q + 1'b1;
      lf_cnt_d = lf_cnt_q + CW'(resp_push) - CW'(pop_lf);

      loads_d = loads_q + CW'(enq & is_load_in) - CW'(pop_lf);

      if (resp_drop) disc_d = disc_q - 1'b1;

      if (retire) begin
        we_d   = e_we_q[q_rd_q] & (e_rd_q[q_rd_q] != '0);
        addr_d = e_rd_q[q_rd_q];
        data_d = head_val;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      q_wr_q   <= '0;
      q_rd_q   <= '0;
      q_cnt_q  <= '0;
      lf_wr_q  <= '0;
      lf_rd_q  <= '0;
      lf_cnt_q <= '0;
      loads_q  <= '0;
      disc_q   <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      q_wr_q   <= q_wr_d;
      q_rd_q   <= q_rd_d;
      q_cnt_q  <= q_cnt_d;
      lf_wr_q  <= lf_wr_d;
      lf_rd_q  <= lf_rd_d;
      lf_cnt_q <= lf_cnt_d;
      loads_q  <= loads_d;
      disc_q   <= disc_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst && enq) begin
      e_load_q[q_wr_q]  <= is_load_in;
      e_sys_q[q_wr_q]   <= is_sys_in;
      e_funct_q[q_wr_q] <= bus.wb_i_funct;
      e_lsb_q[q_wr_q]   <= bus.wb_i_addr_lsb;
      e_we_q[q_wr_q]    <= bus.wb_i_we_rd;
      e_rd_q[q_wr_q]    <= bus.wb_i_rd_addr;
      e_data_q[q_wr_q]  <= bus.wb_i_rd_data;
      e_csr_q[q_wr_q]   <= bus.wb_i_csr;
    end
    if (!wb_rst && resp_push)
      lf_mem_q[lf_wr_q] <= bus.wb_i_data_load;
  end

  assign bus.wb_o_stall    = stall;
  assign bus.wb_o_count    = q_cnt_q;
  assign bus.wb_o_we_rd    = we_q;
  assign bus.wb_o_rd_addr  = addr_q;
  assign bus.wb_o_rd_data  = data_q;
  assign bus.wb_o_load_err = err_q;

endmodule

// File: tb/tb_writeback_buffered.sv
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef SYSTEM
`define SYSTEM 7'b1110011
`endif

module tb_writeback_buffered;
  localparam int DEPTH = 4;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 wb_clk = ~wb_clk;

  wb_if #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .DEPTH(DEPTH)) bus ();

  writeback_buffered #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .DEPTH(DEPTH)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus)
  );

  // Reference model: plain queues of pending instructions and load words.
  typedef struct {
    bit          ld;
    bit          sys;
    logic [2:0]  f;
    logic [1:0]  lsb;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [31:0] csr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mlf[$];
  int          mdisc = 0;
  bit          merr = 0;
  bit          mwe = 0;
  logic [4:0]  maddr = '0;
  logic [31:0] mdata = '0;

  function automatic int m_unans();
    int n = 0;
    foreach (mq[i]) if (mq[i].ld) n++;
    return n - mlf.size();
  endfunction

  function automatic logic [31:0] m_extract(logic [31:0] w, logic [2:0] f, logic [1:0] lsb);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lsb))) & 32'h0000_00FF;
    h = (w >> (16 * int'(lsb[1]))) & 32'h0000_FFFF;
    case (f)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic m_step();
    int   un;
    bit   full;
    ent_t h, n;
    logic [31:0] w;
    if (wb_rst) begin
      mq.delete(); mlf.delete();
      mdisc = 0; merr = 0; mwe = 0; maddr = '0; mdata = '0;
      return;
    end
    un = m_unans();
    if (bus.wb_i_flush) begin
      if (bus.wb_i_load_valid) begin
        if (mdisc > 0 || un > 0) mdisc = mdisc + un - 1;
        else merr = 1;
      end else mdisc = mdisc + un;
      mq.delete(); mlf.delete();
      mwe = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    mwe = 0;
    if (mq.size() > 0 && (!mq[0].ld || mlf.size() > 0)) begin
      h = mq.pop_front();
      if (h.ld) begin
        w = mlf.pop_front();
        mdata = m_extract(w, h.f, h.lsb);
      end else mdata = h.sys ? h.csr : h.d;
      mwe = h.we && (h.rd != 0);
      maddr = h.rd;
    end
    if (bus.wb_i_load_valid) begin
      if (mdisc > 0) mdisc--;
      else if (un > 0) mlf.push_back(bus.wb_i_data_load);
      else merr = 1;
    end
    if (bus.wb_i_ce && !full) begin
      n.ld = (bus.wb_i_opcode == `LOAD);
      n.sys = (bus.wb_i_opcode == `SYSTEM);
      n.f = bus.wb_i_funct; n.lsb = bus.wb_i_addr_lsb; n.we = bus.wb_i_we_rd;
      n.rd = bus.wb_i_rd_addr; n.d = bus.wb_i_rd_data; n.csr = bus.wb_i_csr;
      mq.push_back(n);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
    m_step();
    chk("m_stall", 32'(bus.wb_o_stall), 32'(mq.size() == DEPTH));
    chk("m_count", 32'(bus.wb_o_count), 32'(mq.size()));
    chk("m_we", 32'(bus.wb_o_we_rd), 32'(mwe));
    chk("m_addr", 32'(bus.wb_o_rd_addr), 32'(maddr));
    chk("m_data", bus.wb_o_rd_data, mdata);
    chk("m_err", 32'(bus.wb_o_load_err), 32'(merr));
  endtask

  task automatic set_in(bit ce, logic [6:0] op, logic [2:0] f, logic [1:0] lsb,
                        bit we, logic [4:0] rd, logic [31:0] d, logic [31:0] csr);
    bus.wb_i_ce = ce; bus.wb_i_opcode = op; bus.wb_i_funct = f;
    bus.wb_i_addr_lsb = lsb; bus.wb_i_we_rd = we; bus.wb_i_rd_addr = rd;
    bus.wb_i_rd_data = d; bus.wb_i_csr = csr;
  endtask

  task automatic idle();
    bus.wb_i_ce = 0; bus.wb_i_load_valid = 0; bus.wb_i_flush = 0;
  endtask

  task automatic respond(logic [31:0] w);
    bus.wb_i_load_valid = 1; bus.wb_i_data_load = w;
  endtask

  task automatic load_case(logic [2:0] f, logic [1:0] lsb, logic [31:0] w, logic [31:0] exp);
    set_in(1, `LOAD, f, lsb, 1, 5'd5, 32'h0, 32'h0);
    tick();
    idle();
    tick(); tick();
    respond(w);
    tick();
    idle();
    chk("load_no_bypass", 32'(bus.wb_o_we_rd), 32'd0);
    tick();
    chk("load_we", 32'(bus.wb_o_we_rd), 32'd1);
    chk("load_addr", 32'(bus.wb_o_rd_addr), 32'd5);
    chk("load_data", bus.wb_o_rd_data, exp);
    tick();
  endtask

  initial begin
    idle();
    set_in(0, OP_ALU, 3'd0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    bus.wb_i_data_load = '0;
    wb_rst = 1;
    tick(); tick();
    chk("rst_stall", 32'(bus.wb_o_stall), 32'd0);
    chk("rst_count", 32'(bus.wb_o_count), 32'd0);
    chk("rst_we", 32'(bus.wb_o_we_rd), 32'd0);
    chk("rst_addr", 32'(bus.wb_o_rd_addr), 32'd0);
    chk("rst_data", bus.wb_o_rd_data, 32'd0);
    chk("rst_err", 32'(bus.wb_o_load_err), 32'd0);
    wb_rst = 0;

    // ALU op: visible one edge after acceptance, single-cycle pulse
    set_in(1, OP_ALU, 3'd0, 2'd0, 1, 5'd10, 32'd32, 32'h0);
    tick();
    idle();
    tick();
    chk("alu_we", 32'(bus.wb_o_we_rd), 32'd1);
    chk("alu_addr", 32'(bus.wb_o_rd_addr), 32'd10);
    chk("alu_data", bus.wb_o_rd_data, 32'd32);
    tick();
    chk("alu_pulse", 32'(bus.wb_o_we_rd), 32'd0);
    chk("alu_hold_data", bus.wb_o_rd_data, 32'd32);

    // Sub-word load extraction
    load_case(3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
    load_case(3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080);
    load_case(3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001);

    // CSR path
    set_in(1, `SYSTEM, 3'd1, 2'd0, 1, 5'd4, 32'h1111, 32'h0000_0C5A);
    tick();
    idle();
    tick();
    chk("csr_data", bus.wb_o_rd_data, 32'h0000_0C5A);
    tick();

    // ALU queued behind a slow load stays in order
    set_in(1, `LOAD, 3'b010, 2'd0, 1, 5'd7, 32'h0, 32'h0);
    tick();
    set_in(1, OP_ALU, 3'd0, 2'd0, 1, 5'd3, 32'h33, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("order_wait_we", 32'(bus.wb_o_we_rd), 32'd0);
      chk("order_wait_cnt", 32'(bus.wb_o_count), 32'd2);
    end
    respond(32'h1234_5678);
    tick();
    idle();
    tick();
    chk("order_ld_we", 32'(bus.wb_o_we_rd), 32'd1);
    chk("order_ld_addr", 32'(bus.wb_o_rd_addr), 32'd7);
    chk("order_ld_data", bus.wb_o_rd_data, 32'h1234_5678);
    tick();
    chk("order_alu_we", 32'(bus.wb_o_we_rd), 32'd1);
    chk("order_alu_addr", 32'(bus.wb_o_rd_addr), 32'd3);
    chk("order_alu_data", bus.wb_o_rd_data, 32'h33);
    tick();

    // Fill to DEPTH with unanswered loads
    set_in(1, `LOAD, 3'b010, 2'd0, 1, 5'd9, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) tick();
    chk("full_stall", 32'(bus.wb_o_stall), 32'd1);
    chk("full_count", 32'(bus.wb_o_count), DEPTH);
    set_in(1, OP_ALU, 3'd0, 2'd0, 1, 5'd20, 32'hAA, 32'h0);
    tick();
    chk("full_reject", 32'(bus.wb_o_count), DEPTH);
    respond(32'h0000_0009);
    tick();
    bus.wb_i_load_valid = 0;
    chk("full_resp_cnt", 32'(bus.wb_o_count), DEPTH);
    tick();
    chk("full_retire_cnt", 32'(bus.wb_o_count), DEPTH - 1);
    chk("full_retire_stall", 32'(bus.wb_o_stall), 32'd0);
    tick();
    chk("full_accept_cnt", 32'(bus.wb_o_count), DEPTH);
    idle();
    wb_rst = 1;
    tick();
    wb_rst = 0;

    // Flush with a response in the same cycle
    set_in(1, `LOAD, 3'b010, 2'd0, 1, 5'd11, 32'h0, 32'h0);
    tick();
    set_in(1, `LOAD, 3'b010, 2'd0, 1, 5'd12, 32'h0, 32'h0);
    tick();
    idle();
    bus.wb_i_flush = 1;
    respond(32'hBAD0_0000);
    tick();
    idle();
    chk("flush_count", 32'(bus.wb_o_count), 32'd0);
    chk("flush_we", 32'(bus.wb_o_we_rd), 32'd0);
    set_in(1, `LOAD, 3'b010, 2'd0, 1, 5'd13, 32'h0, 32'h0);
    tick();
    idle();
    chk("flush_new_cnt", 32'(bus.wb_o_count), 32'd1);
    respond(32'hDEAD_0001);
    tick();
    idle();
    tick();
    chk("flush_discard_we", 32'(bus.wb_o_we_rd), 32'd0);
    chk("flush_discard_cnt", 32'(bus.wb_o_count), 32'd1);
    respond(32'hCAFE_0002);
    tick();
    idle();
    tick();
    chk("flush_new_we", 32'(bus.wb_o_we_rd), 32'd1);
    chk("flush_new_addr", 32'(bus.wb_o_rd_addr), 32'd13);
    chk("flush_new_data", bus.wb_o_rd_data, 32'hCAFE_0002);
    chk("flush_err", 32'(bus.wb_o_load_err), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [6:0] op;
      case ($urandom_range(0, 2))
        0:       op = `LOAD;
        1:       op = `SYSTEM;
        default: op = OP_ALU;
      endcase
      set_in($urandom_range(0, 1) == 1, op, 3'($urandom), 2'($urandom),
             $urandom_range(0, 3) != 0, 5'($urandom), $urandom, $urandom);
      bus.wb_i_flush = ($urandom_range(0, 39) == 0);
      bus.wb_i_load_valid = (m_unans() + mdisc > 0) && ($urandom_range(0, 2) == 0);
      bus.wb_i_data_load = $urandom;
      tick();
    end
    idle();
    for (int c = 0; c < 200; c++) begin
      if (mq.size() == 0 && mdisc == 0) break;
      bus.wb_i_load_valid = (m_unans() + mdisc > 0);
      bus.wb_i_data_load = $urandom;
      tick();
    end
    idle();
    tick();
    chk("drain_count", 32'(bus.wb_o_count), 32'd0);
    chk("drain_err", 32'(bus.wb_o_load_err), 32'd0);

    // rd=0 and we=0 never write
    set_in(1, OP_ALU, 3'd0, 2'd0, 1, 5'd0, 32'h55, 32'h0);
    tick();
    set_in(1, OP_ALU, 3'd0, 2'd0, 0, 5'd6, 32'h66, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nowrite_we", 32'(bus.wb_o_we_rd), 32'd0);
    end

    // Unexpected response sets a sticky error
    respond(32'h0);
    tick();
    idle();
    chk("err_set", 32'(bus.wb_o_load_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_sticky", 32'(bus.wb_o_load_err), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_buffered.md
Name: writeback_buffered

Overview:
Parametrised successor to the single-entry writeback stage. Holds up to DEPTH in-order retiring instructions from the memory stage and accepts load data returned a variable number of cycles later. Handles LB/LH/LW/LBU/LHU extraction with byte offset, and selects the CSR result for SYSTEM instructions. Issues at most one register-file write per cycle. Supports flush, including discard of in-flight load responses.

Parameters:
DWIDTH, 32, data width (load extraction defined for 32)
AWIDTH, 5, register address width
FUNCT_WIDTH, 3, funct3 width
DEPTH, 4, instruction queue and load-data FIFO depth (power of 2, >=2)

Ports:
wb_clk  in  1  clock; all state updates on rising edge
wb_rst  in  1  synchronous, active-high reset
wb_i_ce  in  1  entry valid from memory stage
wb_i_opcode  in  `OPCODE_WIDTH  opcode; `LOAD = load path, `SYSTEM = CSR path, otherwise ALU
wb_i_funct  in  FUNCT_WIDTH  funct3 (load size/sign)
wb_i_addr_lsb  in  2  load byte offset
wb_i_we_rd  in  1  instruction writes rd
wb_i_rd_addr  in  AWIDTH  destination register
wb_i_rd_data  in  DWIDTH  ALU result
wb_i_csr  in  DWIDTH  CSR read value
wb_i_load_valid  in  1  load response strobe (in order)
wb_i_data_load  in  DWIDTH  raw load word
wb_i_flush  in  1  discard all queued work
wb_o_stall  out  1  queue full (count==DEPTH)
wb_o_count  out  $clog2(DEPTH)+1  queued entries
wb_o_we_rd  out  1  register-file write strobe
wb_o_rd_addr  out  AWIDTH  write address
wb_o_rd_data  out  DWIDTH  write data
wb_o_load_err  out  1  sticky: unexpected load response

Behaviour:
- Reset: queue, load-data FIFO and discard counter emptied. Outputs reset as follows: stall=0, count=0, we_rd=0, rd_addr=0, rd_data=0, load_err=0. Reset wins over all other inputs.
- Enqueue: when wb_i_ce & !wb_o_stall & !wb_i_flush. Stores opcode class, funct, lsb, we, rd_addr, rd_data, and csr (CSR value captured at enqueue). Full is judged at cycle start; there is no same-cycle free-slot bypass. wb_i_ce while stalled is ignored; upstream holds.
- Load data: a response is pushed into the load-data FIFO when unanswered loads > 0 (loads in queue minus FIFO count) and the discard counter is 0. If the discard counter > 0, the response is dropped and the counter decrements. Otherwise the response is dropped and load_err is set (held until reset).
- Retire (one per cycle, no flush that cycle): the head retires if non-load, or if load and the load-data FIFO is non-empty (pops both). There is no bypass of a same-cycle response.
- Output is registered. Retire decided in cycle N makes wb_o_* visible after edge N.
  - Non-load accepted on edge k: write visible after edge k+1 if the queue was empty.
  - Load response on edge j: write visible after edge j+1.
- wb_o_we_rd = entry.we & (rd_addr!=0), a one-cycle pulse. rd_addr/rd_data hold their last retired values when idle. Entries with we=0 still consume a retire cycle.
- Data select: LOAD gives the extracted value, SYSTEM gives csr, else rd_data.
  - Byte = word[8*lsb+:8], halfword = word[16*lsb[1]+:16].
  - funct 000 sign-extended byte, 001 sign-extended half, 010 word, 100 zero-extended byte, 101 zero-extended half. Other codes give the word.
- Enqueue and retire in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Flush: the queue and load-data FIFO are cleared, and no enqueue, retire or write occurs that cycle. The discard counter is set to its current value + unanswered loads − (wb_i_load_valid that cycle ? 1:0) (response in the flush cycle is consumed by the discard). Subsequent responses are dropped until the counter reaches 0. New entries are accepted the next cycle.

Test Plan:
- Reset held 2 cycles, then ALU op rd=10, rd_data=32, we=1 -> after edge k+1: we_rd=1, rd_addr=10, rd_data=32 for one cycle. Check all reset values first.
- LOAD rd=5 funct=000 lsb=2 enqueued; response 0x0080_0000 three cycles later -> rd_data=0xFFFF_FF80 one cycle after the response. Repeat with funct=100 -> 0x0000_0080, and funct=101 lsb=2 on 0x8001_0000 -> 0x0000_8001.
- LOAD then ALU (rd=3) queued, load response delayed 5 cycles -> ALU write is held behind the load; writes appear in order on consecutive cycles.
- ce held high with no load responses for DEPTH loads -> stall=1 and count=DEPTH; extra entry not accepted. One response followed by retire -> stall drops and the next entry is accepted.
- 2 loads queued, flush with load_valid=1 the same cycle -> queue empty. The next response is discarded, the following is accepted for a newly enqueued load, and load_err stays 0.
- load_valid with no load queued -> load_err=1 and stays 1. Entries with rd=0 or we=0 -> we_rd stays 0.
